serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Parametrised multi-cycle subtractor computing A − B − Bin over WIDTH-bit operands, DIGIT bits per clock, LSB digit first, with a registered borrow chained between digits. Successor to the 1-bit full-subtractor cell: it adds width and throughput/area trade-off parameters, valid/ready handshakes on both sides, and signed-overflow and zero flags. It sits between an operand source and a result consumer in the arithmetic datapath.

## Interface
- WIDTH, 32, operand/result width in bits; must be ≥ 1.
- DIGIT, 4, bits processed per cycle; must satisfy 1 ≤ DIGIT ≤ WIDTH and WIDTH % DIGIT == 0 (elaboration error otherwise).
- clk  input  1  clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  operands and bin are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow in.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  A − B − Bin, modulo 2^WIDTH.
- bout  output  1  final borrow out (unsigned A < B + Bin).
- overflow  output  1  two's-complement overflow of the signed subtraction.
- zero  output  1  diff == 0.

## Operation
- NUM_DIGITS = WIDTH / DIGIT. FSM states: IDLE, RUN, DONE.
- IDLE: in_ready = 1. On in_valid && in_ready, latch a, b; set the borrow register to bin; set the digit counter to 0; go to RUN.
- RUN: each cycle, subtract digit[cnt] of a and b with the borrow register; write the result into diff[cnt*DIGIT +: DIGIT]; update the borrow register with the digit borrow-out; increment cnt. When cnt == NUM_DIGITS−1, also capture bout, overflow and zero, then go to DONE.
- overflow = (borrow into the MSB) XOR (borrow out of the MSB), computed on the final digit.
- zero is evaluated on the complete WIDTH-bit result.
- DONE: out_valid = 1. diff, bout, overflow and zero are held stable. When out_ready = 1, go to IDLE.
- in_ready = 0 in RUN and DONE. in_valid is ignored outside IDLE. A result never reaches the output without being consumed.
- rst, in any state including mid-RUN: go to IDLE on that edge. All outputs take their reset values and the partial operation is discarded.
- Reset values: in_ready = 1 (from the first cycle after rst deasserts), out_valid = 0, diff = 0, bout = 0, overflow = 0, zero = 0.
- NUM_DIGITS == 1 (DIGIT == WIDTH) is legal: RUN lasts a single cycle.

## Timing
- Operands are accepted at edge k. Digits are processed at edges k+1 … k+NUM_DIGITS. out_valid is high starting in the cycle after edge k+NUM_DIGITS. Latency is NUM_DIGITS cycles from the accept edge.
- All outputs are registered. There is no combinational path from any input to any output, including in_valid → in_ready and out_ready → in_ready.
- Result handshake at edge m (out_valid && out_ready): in_ready = 1 in cycle m+1. The next accept is possible at edge m+1.
- Maximum throughput: one result per NUM_DIGITS+2 cycles.
- The critical path is one DIGIT-wide ripple-borrow chain plus the register setup time.

## Structure
- Package serial_subtractor_pkg contains:
  - the state enum type (IDLE, RUN, DONE);
  - a function computing NUM_DIGITS from WIDTH and DIGIT.
- Sub-module digit_subtractor (parameter DIGIT):
  - combinational ripple of DIGIT instances of the team's existing 1-bit full-subtractor cell;
  - ports: a_d, b_d, bin_d → diff_d, bout_d, msb_bin_d (borrow into bit DIGIT−1, used for overflow).
- Top level contains the FSM, digit counter (width $clog2(NUM_DIGITS)+1), operand registers, borrow register and result register.

## Test plan
All scenarios use WIDTH=8, DIGIT=4 (NUM_DIGITS=2) unless stated.
- a=0x05, b=0x03, bin=0, accept at edge k → out_valid after edge k+2; diff=0x02, bout=0, overflow=0, zero=0.
- a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1, overflow=0, zero=0.
- a=0x80, b=0x01, bin=0 → diff=0x7F, bout=0, overflow=1.
- a=0x10, b=0x0F, bin=1 (borrow crosses the digit boundary) → diff=0x00, bout=0, zero=1.
- Hold out_ready=0 for 5 cycles after out_valid rises while driving in_valid=1 with new operands → outputs stable and in_ready=0 throughout, new operands not taken. Raise out_ready → in_ready=1 next cycle, new operands accepted and correct result produced.
- Assert rst for one cycle mid-RUN → IDLE next cycle, out_valid=0, all outputs 0. Then a=0xFF, b=0xFF, bin=1 → diff=0xFF, bout=1. Repeat with WIDTH=8, DIGIT=8 (single-cycle RUN) and WIDTH=8, DIGIT=1.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
package serial_subtractor_pkg;

  // Controller states: waiting for operands, walking digits, holding a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of DIGIT-wide slices in a WIDTH-bit operand.
  function automatic int num_digits(input int width, input int digit);
    return (digit > 0) ? (width / digit) : 0;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// 1-bit full-subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_digit.sv
// One DIGIT-wide ripple-borrow slice built from full-subtractor cells.
module digit_subtractor #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             bin_d,
  output logic [DIGIT-1:0] diff_d,
  output logic             bout_d,
  output logic             msb_bin_d
);

  // borrow_chain[i] is the borrow into bit i; the last entry leaves the slice.
  logic [DIGIT:0] borrow_chain;

  assign borrow_chain[0] = bin_d;

  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_cell
    full_subtractor u_cell (
      .a    (a_d[gi]),
      .b    (b_d[gi]),
      .bin  (borrow_chain[gi]),
      .d    (diff_d[gi]),
      .bout (borrow_chain[gi+1])
    );
  end

  assign bout_d    = borrow_chain[DIGIT];
  // Borrow into the top bit of the slice; only meaningful on the final digit.
  assign msb_bin_d = borrow_chain[DIGIT-1];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: A - B - Bin, DIGIT bits per clock, LSB digit first,
// with valid/ready handshakes and registered borrow/overflow/zero results.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow,
  output logic             zero
);

  localparam int NUM_DIGITS = num_digits(WIDTH, DIGIT);
  localparam int CNT_W      = $clog2(NUM_DIGITS) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

  if ((WIDTH < 1) || (DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
    $error("serial_subtractor: need 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
  end

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  // Operands shift right one digit per cycle so the active digit is always at bit 0.
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             borrow_reg;
  // Running "all digits so far were zero" flag.
  logic             zacc_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             bout_reg;
  logic             overflow_reg;
  logic             zero_reg;

  logic [DIGIT-1:0] dig_diff;
  logic             dig_bout;
  logic             dig_msb_bin;
  logic             dig_zero;
  logic             last_digit;

  digit_subtractor #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a_d       (a_reg[DIGIT-1:0]),
    .b_d       (b_reg[DIGIT-1:0]),
    .bin_d     (borrow_reg),
    .diff_d    (dig_diff),
    .bout_d    (dig_bout),
    .msb_bin_d (dig_msb_bin)
  );

  assign dig_zero   = (dig_diff == '0);
  assign last_digit = (cnt_reg == LAST_CNT);

  // Control FSM, operand/borrow datapath and final flag capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      borrow_reg    <= 1'b0;
      zacc_reg      <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      bout_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
      zero_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg        <= a;
            b_reg        <= b;
            borrow_reg   <= bin;
            cnt_reg      <= '0;
            zacc_reg     <= 1'b1;
            in_ready_reg <= 1'b0;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          a_reg      <= a_reg >> DIGIT;
          b_reg      <= b_reg >> DIGIT;
          borrow_reg <= dig_bout;
          cnt_reg    <= cnt_reg + 1'b1;
          zacc_reg   <= zacc_reg & dig_zero;
          if (last_digit) begin
            bout_reg      <= dig_bout;
            overflow_reg  <= dig_msb_bin ^ dig_bout;
            zero_reg      <= zacc_reg & dig_zero;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Result register, one slice per digit, written when that digit is processed.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_result
    logic [DIGIT-1:0] slice_reg;

    // Capture this digit's difference on its RUN cycle; hold otherwise.
    always_ff @(posedge clk) begin
      if (rst) begin
        slice_reg <= '0;
      end else if ((state_reg == RUN) && (cnt_reg == CNT_W'(gi))) begin
        slice_reg <= dig_diff;
      end
    end

    assign diff[gi*DIGIT +: DIGIT] = slice_reg;
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign bout      = bout_reg;
  assign overflow  = overflow_reg;
  assign zero      = zero_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 with DIGIT=4, 8 and 1.
module tb_serial_subtractor;

  logic clk;
  int   checks;
  int   failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic check(input int cfg, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL cfg%0d %s actual=0x%0h required=0x%0h", cfg, name, act, exp);
    end
  endtask

  // Reference result from plain integer arithmetic: {zero, overflow, bout, diff}.
  function automatic logic [10:0] ref_sub(input logic [7:0] a, input logic [7:0] b, input logic bin);
    int ur;
    int sr;
    logic [7:0] d;
    ur = int'(a) - int'(b) - int'(bin);
    sr = int'($signed(a)) - int'($signed(b)) - int'(bin);
    d  = ur[7:0];
    return {(d == 8'd0), ((sr > 127) || (sr < -128)), (ur < 0), d};
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int DG = (gi == 0) ? 4 : ((gi == 1) ? 8 : 1);
    localparam int ND = 8 / DG;

    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       bout;
    logic       overflow;
    logic       zero;
    bit         cmp_en;
    bit         done_c;

    // Model state
    logic       m_ready;
    logic       m_valid;
    int         m_cnt;
    logic [10:0] m_pend;
    logic [10:0] m_res;

    serial_subtractor #(
      .WIDTH (8),
      .DIGIT (DG)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout),
      .overflow  (overflow),
      .zero      (zero)
    );

    // Transaction-level model: accept when ready, result appears ND edges later,
    // held until consumed.
    always @(posedge clk) begin
      if (rst) begin
        m_ready <= 1'b1;
        m_valid <= 1'b0;
        m_cnt   <= 0;
        m_pend  <= '0;
        m_res   <= '0;
      end else if (m_ready && in_valid) begin
        m_ready <= 1'b0;
        m_cnt   <= ND;
        m_pend  <= ref_sub(a, b, bin);
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_valid <= 1'b1;
          m_res   <= m_pend;
        end
      end else if (m_valid && out_ready) begin
        m_valid <= 1'b0;
        m_ready <= 1'b1;
      end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
      if (cmp_en) begin
        check(gi, "in_ready", in_ready, m_ready);
        check(gi, "out_valid", out_valid, m_valid);
        if (m_valid) begin
          check(gi, "diff", diff, m_res[7:0]);
          check(gi, "bout", bout, m_res[8]);
          check(gi, "overflow", overflow, m_res[9]);
          check(gi, "zero", zero, m_res[10]);
        end
      end
    end

    task automatic step();
      @(posedge clk);
      #2;
    endtask

    task automatic wait_ready();
      int n;
      n = 0;
      while ((in_ready !== 1'b1) && (n < 100)) begin
        step();
        n++;
      end
      if (n >= 100) check(gi, "ready_timeout", 32'(n), 32'd0);
    endtask

    task automatic check_reset_outputs();
      check(gi, "rst_in_ready", in_ready, 1'b1);
      check(gi, "rst_out_valid", out_valid, 1'b0);
      check(gi, "rst_diff", diff, 8'h00);
      check(gi, "rst_bout", bout, 1'b0);
      check(gi, "rst_overflow", overflow, 1'b0);
      check(gi, "rst_zero", zero, 1'b0);
    endtask

    // One operation with hand-computed expectations and latency check.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                          input logic [7:0] ed, input logic eb, input logic eo, input logic ez);
      a = ta; b = tb; bin = tbin; in_valid = 1'b1;
      wait_ready();
      step();                       // accept edge k
      in_valid = 1'b0;
      check(gi, "busy_in_ready", in_ready, 1'b0);
      for (int i = 0; i < ND - 1; i++) step();
      check(gi, "lat_early", out_valid, 1'b0);
      step();                       // edge k+ND
      check(gi, "lat_valid", out_valid, 1'b1);
      check(gi, "lit_diff", diff, ed);
      check(gi, "lit_bout", bout, eb);
      check(gi, "lit_overflow", overflow, eo);
      check(gi, "lit_zero", zero, ez);
      $display("txn cfg=%0d a=%02h b=%02h bin=%0d -> diff=%02h bout=%0d ovf=%0d zero=%0d",
               gi, ta, tb, tbin, diff, bout, overflow, zero);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check(gi, "post_in_ready", in_ready, 1'b1);
      check(gi, "post_out_valid", out_valid, 1'b0);
    endtask

    // Result back-pressure with a new request waiting on the input.
    task automatic stall_test();
      a = 8'h05; b = 8'h03; bin = 1'b0; in_valid = 1'b1;
      wait_ready();
      step();
      a = 8'h00; b = 8'h01; bin = 1'b0;   // new operands, still valid
      for (int i = 0; i < ND; i++) step();
      check(gi, "stall_valid", out_valid, 1'b1);
      for (int i = 0; i < 5; i++) begin
        step();
        check(gi, "stall_hold_valid", out_valid, 1'b1);
        check(gi, "stall_in_ready", in_ready, 1'b0);
        check(gi, "stall_diff", diff, 8'h02);
      end
      out_ready = 1'b1;
      step();                           // handshake edge m
      out_ready = 1'b0;
      check(gi, "stall_release_ready", in_ready, 1'b1);
      step();                           // accept at m+1
      in_valid = 1'b0;
      check(gi, "stall_accepted", in_ready, 1'b0);
      for (int i = 0; i < ND; i++) step();
      check(gi, "stall2_valid", out_valid, 1'b1);
      check(gi, "stall2_diff", diff, 8'hFF);
      check(gi, "stall2_bout", bout, 1'b1);
      $display("txn cfg=%0d stalled a=00 b=01 -> diff=%02h bout=%0d", gi, diff, bout);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    endtask

    initial begin
      cmp_en = 1'b0; done_c = 1'b0;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; bin = 1'b0;
      step();
      cmp_en = 1'b1;
      step();
      rst = 1'b0;
      check_reset_outputs();
      run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
      run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
      run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
      run_op(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
      run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);
      stall_test();
      // Reset in the middle of an operation.
      a = 8'h12; b = 8'h34; bin = 1'b0; in_valid = 1'b1;
      wait_ready();
      step();
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_reset_outputs();
      $display("txn cfg=%0d reset mid-run", gi);
      run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
      step();
      done_c = 1'b1;
    end
  end

  initial begin
    int n;
    checks = 0;
    failures = 0;
    n = 0;
    while (!(g_cfg[0].done_c && g_cfg[1].done_c && g_cfg[2].done_c) && (n < 20000)) begin
      @(posedge clk);
      n++;
    end
    if (n >= 20000) begin
      checks++;
      failures++;
      $display("FAIL global_timeout actual=%0d required<20000", n);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
